// File: rtl/module_input_conditioner_pkg.sv
// Shared widths and vector types for the board-input conditioner.
package pkg_input_cond;
  localparam int SW_WIDTH = 16;
  localparam int NUM_BTN  = 4;
  localparam int NIBBLE_W = 4;

  typedef logic [SW_WIDTH-1:0] sw_word_t;
  typedef logic [NUM_BTN-1:0]  btn_vec_t;
endpackage

// File: rtl/module_input_conditioner_debouncer.sv
// One push-button: synchronizer chain, consecutive-mismatch debounce counter,
// debounced level and a one-cycle registered press pulse.
module module_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic clk_pi,
  input  logic rst_n_pi,
  input  logic btn_pi,
  output logic level_po,
  output logic rise_po
);
  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic [CNT_W-1:0]       cnt_p1;
  logic                   db_p1;
  logic                   rise_p1;
  logic                   b_sync;
  logic                   commit;

  assign b_sync = sync_p0[SYNC_STAGES-1];
  // The counter saturates at CNT_LAST: reaching it with a still-mismatching input commits.
  assign commit = (b_sync != db_p1) && (cnt_p1 == CNT_LAST);

  // sync -> debounce stage
  always_ff @(posedge clk_pi or negedge rst_n_pi) begin
    if (!rst_n_pi) begin
      sync_p0 <= '0;
      cnt_p1  <= '0;
      db_p1   <= 1'b0;
      rise_p1 <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], btn_pi};
      if (b_sync == db_p1) begin
        cnt_p1 <= '0;
      end else if (commit) begin
        db_p1  <= b_sync;
        cnt_p1 <= '0;
      end else begin
        cnt_p1 <= cnt_p1 + 1'b1;
      end
      rise_p1 <= commit & b_sync;
    end
  end

  assign level_po = db_p1;
  assign rise_po  = rise_p1;
endmodule

// File: rtl/module_input_conditioner.sv
// Board-input front end: synchronized switch word with optional hold, and
// debounced buttons that each toggle one nibble enable per press.
module module_input_conditioner
  import pkg_input_cond::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic     clk_pi,
  input  logic     rst_n_pi,
  input  sw_word_t sw_pi,
  input  btn_vec_t btn_pi,
  input  logic     lock_pi,
  output sw_word_t s_po,
  output btn_vec_t en_po,
  output btn_vec_t btn_pulse_po
);
  logic [SYNC_STAGES-1:0][SW_WIDTH-1:0] sw_sync_p0;
  logic [SYNC_STAGES-1:0]               lock_sync_p0;
  sw_word_t                             s_p1;
  btn_vec_t                             en_p2;
  btn_vec_t                             rise;
  btn_vec_t                             db_level_unused;

  // switch/lock sync -> held word stage
  always_ff @(posedge clk_pi or negedge rst_n_pi) begin
    if (!rst_n_pi) begin
      sw_sync_p0   <= '0;
      lock_sync_p0 <= '0;
      s_p1         <= '0;
    end else begin
      sw_sync_p0   <= {sw_sync_p0[SYNC_STAGES-2:0], sw_pi};
      lock_sync_p0 <= {lock_sync_p0[SYNC_STAGES-2:0], lock_pi};
      if (!lock_sync_p0[SYNC_STAGES-1]) begin
        s_p1 <= sw_sync_p0[SYNC_STAGES-1];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      module_debouncer #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
        .clk_pi  (clk_pi),
        .rst_n_pi(rst_n_pi),
        .btn_pi  (btn_pi[gi]),
        .level_po(db_level_unused[gi]),
        .rise_po (rise[gi])
      );
    end
  endgenerate

  // press pulse -> enable toggle stage
  always_ff @(posedge clk_pi or negedge rst_n_pi) begin
    if (!rst_n_pi) begin
      en_p2 <= '0;
    end else begin
      en_p2 <= en_p2 ^ rise;
    end
  end

  // The stored parity lags the pulse by one edge; folding the live pulse back in
  // makes the toggle visible on the same edge the pulse rises.
  assign en_po        = en_p2 ^ rise;
  assign s_po         = s_p1;
  assign btn_pulse_po = rise;
endmodule

// File: tb/tb_module_input_conditioner.sv
// Directed bench for module_input_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_module_input_conditioner;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] sw = 16'h0000;
  logic [3:0]  btn = 4'h0;
  logic        lock = 1'b0;
  logic [15:0] s_out;
  logic [3:0]  en_out;
  logic [3:0]  pulse_out;

  int checks = 0;
  int errors = 0;
  int pulse_cnt [4];

  always #5 clk = ~clk;

  module_input_conditioner #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk_pi      (clk),
    .rst_n_pi    (rst_n),
    .sw_pi       (sw),
    .btn_pi      (btn),
    .lock_pi     (lock),
    .s_po        (s_out),
    .en_po       (en_out),
    .btn_pulse_po(pulse_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n edges, sampling 1 ns after each and tallying pulses per bit.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      for (int b = 0; b < 4; b++) pulse_cnt[b] += int'(pulse_out[b]);
    end
  endtask

  task automatic clear_counts();
    for (int b = 0; b < 4; b++) pulse_cnt[b] = 0;
  endtask

  initial begin
    clear_counts();
    // 1. asynchronous reset while inputs are active
    sw  = 16'h1234;
    btn = 4'hF;
    step(4);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_s", s_out, 16'h0000);
    check_eq("rst_en", en_out, 4'h0);
    check_eq("rst_pulse", pulse_out, 4'h0);
    step(2);
    check_eq("rst_hold_s", s_out, 16'h0000);
    btn = 4'h0;
    step(1);
    rst_n = 1'b1;

    // 2. switch latency and lock
    step(2);
    check_eq("sw_edge2", s_out, 16'h0000);
    step(1);
    check_eq("sw_edge3", s_out, 16'h1234);
    lock = 1'b1;
    step(3);
    sw = 16'h2321;
    step(6);
    check_eq("lock_hold", s_out, 16'h1234);
    lock = 1'b0;
    step(2);
    check_eq("unlock_edge2", s_out, 16'h1234);
    step(1);
    check_eq("unlock_edge3", s_out, 16'h2321);

    // 3. clean press on bit 3, held 20 cycles
    clear_counts();
    btn = 4'b1000;
    step(5);
    check_eq("press3_edge5_pulse", pulse_out, 4'h0);
    check_eq("press3_edge5_en", en_out, 4'h0);
    step(1);
    check_eq("press3_edge6_pulse", pulse_out, 4'b1000);
    check_eq("press3_edge6_en", en_out, 4'b1000);
    step(1);
    check_eq("press3_edge7_pulse", pulse_out, 4'h0);
    step(13);
    check_eq("press3_single", pulse_cnt[3], 1);
    check_eq("press3_en_held", en_out, 4'b1000);
    btn = 4'b0000;
    step(10);
    check_eq("release3_en", en_out, 4'b1000);
    check_eq("release3_nopulse", pulse_cnt[3], 1);
    btn = 4'b1000;
    step(10);
    check_eq("repress3_en", en_out, 4'b0000);
    check_eq("repress3_pulses", pulse_cnt[3], 2);
    btn = 4'b0000;
    step(10);

    // 4. bounce on bit 0: runs of three highs never qualify
    clear_counts();
    for (int r = 0; r < 6; r++) begin
      btn[0] = 1'b1;
      step(3);
      btn[0] = 1'b0;
      step(1);
    end
    step(6);
    check_eq("bounce_nopulse", pulse_cnt[0], 0);
    check_eq("bounce_en", en_out, 4'b0000);
    btn[0] = 1'b1;
    step(12);
    check_eq("held0_single", pulse_cnt[0], 1);
    check_eq("held0_en", en_out, 4'b0001);
    btn = 4'b0000;
    step(10);

    // 5. simultaneous press on bits 0..2
    clear_counts();
    btn = 4'b0111;
    step(5);
    check_eq("simul_edge5", pulse_out, 4'h0);
    step(1);
    check_eq("simul_pulse", pulse_out, 4'b0111);
    check_eq("simul_en", en_out, 4'b0110);
    step(1);
    check_eq("simul_drop", pulse_out, 4'h0);
    btn = 4'b0000;
    step(10);

    // 6. reset while bit 1 is mid-count (cnt=2 after edge 4)
    clear_counts();
    btn = 4'b0010;
    step(4);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_en", en_out, 4'h0);
    step(1);
    rst_n = 1'b1;
    step(5);
    check_eq("midrst_edge5", pulse_cnt[1], 0);
    step(1);
    check_eq("midrst_pulse", pulse_out, 4'b0010);
    check_eq("midrst_en1", en_out, 4'b0010);
    step(4);
    check_eq("midrst_single", pulse_cnt[1], 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
